// File: rtl/datamemory_wait_responder.sv
// ---------------------------------------------------------------------------
// datamemory_wait_responder
//
// This is a multi-cycle, word-addressed data memory for the load/store port of
// the MIPS datapath. A request (memRead or memWrite) is captured in IDLE. After
// LATENCY edges the access is performed. The block then pulses ready for one
// cycle so that the processor can release its PC stall.
//
// Parameters:
//   DEPTH   - number of 32-bit words; legal addresses are 0..DEPTH-1
//   ADDR_W  - array index width, 2**ADDR_W >= DEPTH
//   LATENCY - edges from acceptance to response, 1..15
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous, active-high reset
//   addr       in  32   word address (captured at acceptance)
//   writeData  in  32   store data (captured at acceptance)
//   memRead    in   1   load request
//   memWrite   in   1   store request
//   readData   out 32   registered load result, holds until next load/reset
//   ready      out  1   one-cycle completion pulse
//   busy       out  1   high while an access is counting down
//   error      out  1   qualifies ready: access was illegal
//   rdCount    out 16   legal loads completed, saturating (DATAMEM_PERF_EN)
//   wrCount    out 16   legal stores completed, saturating (DATAMEM_PERF_EN)
//
// Optional feature macro: DATAMEM_PERF_EN adds the rdCount/wrCount ports.
// ---------------------------------------------------------------------------
module datamemory_wait_responder #(
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] writeData,
   input  logic        memRead,
   input  logic        memWrite,
   output logic [31:0] readData,
   output logic        ready,
   output logic        busy,
   output logic        error
`ifdef DATAMEM_PERF_EN
   ,
   output logic [15:0] rdCount,
   output logic [15:0] wrCount
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_t;

   localparam logic [3:0]  LOAD_CNT  = 4'(LATENCY - 1);
   localparam logic [31:0] DEPTH_W32 = 32'(DEPTH);

   state_t      r_state;
   logic [3:0]  r_count;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_rd;
   logic        r_wr;
   logic [31:0] r_mem [DEPTH];

   // The range check uses the full captured address. An address at or above
   // DEPTH is rejected and never aliases into the array.
   wire              w_in_range = (r_addr < DEPTH_W32);
   wire [ADDR_W-1:0] w_index    = r_addr[ADDR_W-1:0];
   wire              w_legal_rd = r_rd & ~r_wr & w_in_range;
   wire              w_legal_wr = r_wr & ~r_rd & w_in_range;
   // The response edge is the last BUSY edge, when the countdown has reached zero.
   wire              w_done     = (r_state == ST_BUSY) && (r_count == 4'd0);

   // NOTE: the array has no reset branch. Contents must survive rst, and a
   // resettable array would also prevent RAM inference. An aborted store never
   // writes, because reset forces r_state out of BUSY before any w_done edge.
   always_ff @(posedge clk) begin
      if (w_done && w_legal_wr)
         r_mem[w_index] <= r_wdata;
   end

   // NOTE: every register in this block uses a non-blocking assignment. The
   // outputs and the captured request therefore all update together at the
   // edge, whatever order the statements are written in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_count  <= 4'd0;
         r_addr   <= 32'd0;
         r_wdata  <= 32'd0;
         r_rd     <= 1'b0;
         r_wr     <= 1'b0;
         readData <= 32'd0;
         ready    <= 1'b0;
         busy     <= 1'b0;
         error    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               ready <= 1'b0;
               error <= 1'b0;
               if (memRead || memWrite) begin
                  r_addr  <= addr;
                  r_wdata <= writeData;
                  r_rd    <= memRead;
                  r_wr    <= memWrite;
                  r_count <= LOAD_CNT;
                  busy    <= 1'b1;
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (r_count == 4'd0) begin
                  busy    <= 1'b0;
                  ready   <= 1'b1;
                  error   <= ~(w_legal_rd | w_legal_wr);
                  r_state <= ST_RESP;
                  // A load with both strobes set is illegal and leaves readData
                  // unchanged. An out-of-range load returns zero.
                  if (r_rd && !r_wr)
                     readData <= w_in_range ? r_mem[w_index] : 32'd0;
               end else begin
                  r_count <= r_count - 4'd1;
               end
            end
            ST_RESP: begin
               // A request present in this cycle is ignored. It is accepted on
               // the following edge if the requester still holds it in IDLE.
               ready   <= 1'b0;
               error   <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               ready   <= 1'b0;
               error   <= 1'b0;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef DATAMEM_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdCount <= 16'd0;
         wrCount <= 16'd0;
      end else if (w_done) begin
         if (w_legal_rd && rdCount != 16'hFFFF)
            rdCount <= rdCount + 16'd1;
         if (w_legal_wr && wrCount != 16'hFFFF)
            wrCount <= wrCount + 16'd1;
      end
   end
`endif

endmodule
